cell_regfile: RTL and testbench
===============================

# cell_regfile

Register file and command stage sitting directly downstream of the coprocessor's AXI-Lite slave front-end. It accepts single-beat register read/write requests over a valid/ready request/response pair and holds double-buffered coefficient registers (shadow written by software, active driven to the compute cell). It sequences commit and start commands against the compute cell's busy/done handshake and returns AXI-coded responses for the front-end to forward.

## Interface
- DATA_WIDTH, 32, register and data bus width
- NUM_COEF, 8, number of coefficient registers (1..16)
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  byte address, bits [1:0] ignored
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte enables
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_rdata  out  DATA_WIDTH  read data, 0 on writes and errors
- resp_code  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- coef_active  out  NUM_COEF*DATA_WIDTH  active coefficients, coef 0 in LSBs
- core_start  out  1  one-cycle start pulse
- core_busy  in  1  compute cell running
- core_done  in  1  one-cycle completion pulse
- core_result  in  DATA_WIDTH  result, valid with core_done

## Operation
- Register map: 0x00 CTRL (W: bit0 START, bit1 COMMIT; both self-clearing, read as 0); 0x04 STATUS (RO bit0 busy = core_busy, bit1 commit_pending, bit2 start_pending; bit3 done sticky, W1C); 0x08 RESULT (RO, latched on core_done); 0x10 + 4*i COEF shadow i, RW, i < NUM_COEF.
- Writes honour req_wstrb per byte on COEF and STATUS; CTRL acts on bits whose byte strobe is set.
- Unmapped address: DECERR, no side effects. Write to RESULT: SLVERR, no change. Write to STATUS bits other than 3 ignored, OKAY.
- COMMIT: sets commit_pending; applied (shadow -> coef_active, pending cleared) in first cycle with core_busy low.
- START: sets start_pending; core_start pulses in first cycle with core_busy low and commit_pending low; start_pending clears on that pulse.
- START and COMMIT in same write: commit applies first, core_start pulses the following cycle.
- core_done: RESULT <= core_result, done <= 1. Simultaneous done set and W1C: set wins.
- Repeated START while start_pending: absorbed, single pulse.
- Reset: req_ready 1, resp_valid 0, resp_rdata 0, resp_code 0, coef_active 0, shadows 0, core_start 0, all pending/done flags 0, RESULT 0.

## Timing
- One outstanding request: req_ready = !resp_valid.
- Accept in cycle N -> resp_valid high in N+1; resp_* held stable until resp_valid && resp_ready; req_ready rises the cycle after.
- Write side effects (shadow, flags) visible in N+1; commit earliest N+1 to coef_active at N+2; core_start earliest at N+2 (N+3 if commit also pending).
- Reads return register state as of cycle N.
- Reset mid-operation: all state cleared in the next cycle regardless of handshakes; pending commands discarded.

## Configuration
- CELL_REGFILE_CYCLE_CNT_EN defined: 0x0C CYCLES (RO) counts cycles with core_busy high, cleared on core_start, saturates at all-ones; write to it SLVERR.
- Not defined: no counter logic; 0x0C decodes DECERR.

## Structure
- Shared package cell_pkg: RESP_OKAY/RESP_SLVERR/RESP_DECERR codes, register offset constants, CTRL/STATUS bit indices.
- Sub-module cell_commit_ctrl: commit_pending/start_pending flags, core_busy gating, commit and core_start generation; regfile decode/response logic stays in the top.

## Test plan
- Write COEF2 = 0x1234_5678 strobe 0xF, read back -> OKAY, 0x1234_5678; coef_active unchanged (0).
- Write COEF0 = 0xAABB_CCDD strobe 0x3 over 0 -> reads 0x0000_CCDD.
- core_busy high, write CTRL = 0x3 -> STATUS reads 0x7; drop busy -> coef_active updates that cycle, core_start pulses exactly once next cycle.
- core_done with core_result = 0xDEAD_BEEF -> RESULT reads 0xDEAD_BEEF, STATUS bit3 = 1; write STATUS 0x8 -> bit3 = 0.
- Read 0x40 -> DECERR, rdata 0; write RESULT -> SLVERR, RESULT unchanged; hold resp_ready low 5 cycles -> response stable, req_ready low throughout.
- Assert aresetn low with commit_pending set -> next cycle all outputs at reset values, no core_start after release.

Source files
------------

// File: rtl/cell_pkg.sv
// Shared constants for the coprocessor register file: response codes,
// register offsets and CTRL/STATUS bit positions.
package cell_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_RESULT    = 8'h08;
  localparam logic [7:0] ADDR_CYCLES    = 8'h0C;
  localparam logic [7:0] ADDR_COEF_BASE = 8'h10;

  localparam logic [5:0] WORD_CTRL   = ADDR_CTRL[7:2];
  localparam logic [5:0] WORD_STATUS = ADDR_STATUS[7:2];
  localparam logic [5:0] WORD_RESULT = ADDR_RESULT[7:2];
  localparam logic [5:0] WORD_CYCLES = ADDR_CYCLES[7:2];
  localparam logic [5:0] WORD_COEF   = ADDR_COEF_BASE[7:2];

  localparam int CTRL_START    = 0;
  localparam int CTRL_COMMIT   = 1;
  localparam int STATUS_BUSY   = 0;
  localparam int STATUS_COMMIT = 1;
  localparam int STATUS_START  = 2;
  localparam int STATUS_DONE   = 3;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_RESULT,
    REG_CYCLES,
    REG_COEF,
    REG_NONE
  } reg_sel_e;

  // Word index of a byte address; the two LSBs never select anything.
  function automatic logic [5:0] word_of(input logic [7:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/cell_regfile_if.sv
// Single-beat request/response channel between the AXI-Lite front-end
// (master) and the register file (slave).
interface cell_regfile_if #(
  parameter int DATA_WIDTH = 32
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [7:0]              req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic [1:0]              resp_code;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_code
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_code
  );

endinterface

// File: rtl/cell_commit_ctrl.sv
// Commit/start sequencing against the compute cell busy handshake.
// Commit waits for an idle cell; start additionally waits for the commit.
module cell_commit_ctrl (
  input  logic aclk,
  input  logic aresetn,
  input  logic commit_req,
  input  logic start_req,
  input  logic core_busy,
  output logic commit_pending,
  output logic start_pending,
  output logic commit_apply,
  output logic core_start
);

  logic start_fire;

  assign commit_apply = commit_pending && !core_busy;
  assign start_fire   = start_pending && !commit_pending && !core_busy;

  // A start arriving on the edge that fires the pulse is absorbed into it;
  // a commit arriving while one is applied re-arms so the newer shadow wins.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      commit_pending <= 1'b0;
      start_pending  <= 1'b0;
      core_start     <= 1'b0;
    end else begin
      commit_pending <= commit_req || (commit_pending && !commit_apply);
      start_pending  <= start_fire ? 1'b0 : (start_pending || start_req);
      core_start     <= start_fire;
    end
  end

endmodule

// File: rtl/cell_regfile.sv
// Coprocessor register file: decode/response, double-buffered coefficients,
// RESULT/done capture. Optional busy-cycle counter: CELL_REGFILE_CYCLE_CNT_EN.
module cell_regfile
  import cell_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COEF   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  cell_regfile_if.slave                  bus,
  output logic [NUM_COEF*DATA_WIDTH-1:0] coef_active,
  output logic                           core_start,
  input  logic                           core_busy,
  input  logic                           core_done,
  input  logic [DATA_WIDTH-1:0]          core_result
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  accept;
  logic                  wr;
  logic [5:0]            word;
  reg_sel_e              sel;
  logic [NUM_COEF-1:0]   coef_hit;
  logic [NUM_COEF-1:0]   coef_we;
  logic [DATA_WIDTH-1:0] coef_rd;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rsp_data_p0;
  logic [1:0]            rsp_code_p0;
  logic                  start_req;
  logic                  commit_req;
  logic                  done_clr;
  logic                  commit_pending;
  logic                  start_pending;
  logic                  commit_apply;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] shadow [NUM_COEF];
  logic                  unused_addr_lsb;
`ifdef CELL_REGFILE_CYCLE_CNT_EN
  logic [DATA_WIDTH-1:0] cycles_q;
`endif

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign bus.req_ready   = !bus.resp_valid;
  assign accept          = bus.req_valid && bus.req_ready;
  assign wr              = accept && bus.req_write;
  assign word            = word_of(bus.req_addr);

  // ---- decode: request in cycle N sees register state of cycle N ----
  always_comb begin
    sel      = REG_NONE;
    coef_hit = '0;
    coef_rd  = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (word == WORD_COEF + 6'(i)) begin
        coef_hit[i] = 1'b1;
        coef_rd     = shadow[i];
        sel         = REG_COEF;
      end
    end
    if (word == WORD_CTRL)   sel = REG_CTRL;
    if (word == WORD_STATUS) sel = REG_STATUS;
    if (word == WORD_RESULT) sel = REG_RESULT;
`ifdef CELL_REGFILE_CYCLE_CNT_EN
    if (word == WORD_CYCLES) sel = REG_CYCLES;
`endif
  end

  always_comb begin
    status_word                = '0;
    status_word[STATUS_BUSY]   = core_busy;
    status_word[STATUS_COMMIT] = commit_pending;
    status_word[STATUS_START]  = start_pending;
    status_word[STATUS_DONE]   = done_q;
  end

  always_comb begin
    rsp_code_p0 = RESP_DECERR;
    rsp_data_p0 = '0;
    start_req   = 1'b0;
    commit_req  = 1'b0;
    done_clr    = 1'b0;
    coef_we     = '0;
    case (sel)
      REG_CTRL: begin
        rsp_code_p0 = RESP_OKAY;
        start_req   = wr && bus.req_wstrb[0] && bus.req_wdata[CTRL_START];
        commit_req  = wr && bus.req_wstrb[0] && bus.req_wdata[CTRL_COMMIT];
      end
      REG_STATUS: begin
        rsp_code_p0 = RESP_OKAY;
        rsp_data_p0 = status_word;
        done_clr    = wr && bus.req_wstrb[0] && bus.req_wdata[STATUS_DONE];
      end
      REG_RESULT: begin
        rsp_code_p0 = bus.req_write ? RESP_SLVERR : RESP_OKAY;
        rsp_data_p0 = result_q;
      end
`ifdef CELL_REGFILE_CYCLE_CNT_EN
      REG_CYCLES: begin
        rsp_code_p0 = bus.req_write ? RESP_SLVERR : RESP_OKAY;
        rsp_data_p0 = cycles_q;
      end
`endif
      REG_COEF: begin
        rsp_code_p0 = RESP_OKAY;
        rsp_data_p0 = coef_rd;
        coef_we     = coef_hit & {NUM_COEF{wr}};
      end
      default: rsp_code_p0 = RESP_DECERR;
    endcase
    if (bus.req_write || rsp_code_p0 != RESP_OKAY) rsp_data_p0 = '0;
  end

  // ---- response stage: held until the front-end consumes it ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_code  <= RESP_OKAY;
    end else if (accept) begin
      bus.resp_valid <= 1'b1;
      bus.resp_rdata <= rsp_data_p0;
      bus.resp_code  <= rsp_code_p0;
    end else if (bus.resp_valid && bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end

  cell_commit_ctrl u_commit_ctrl (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .commit_req     (commit_req),
    .start_req      (start_req),
    .core_busy      (core_busy),
    .commit_pending (commit_pending),
    .start_pending  (start_pending),
    .commit_apply   (commit_apply),
    .core_start     (core_start)
  );

  // ---- register state: shadows, active bank, result capture ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_COEF; i++) shadow[i] <= '0;
      coef_active <= '0;
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (coef_we[i]) shadow[i] <= merge_bytes(shadow[i], bus.req_wdata, bus.req_wstrb);
        if (commit_apply) coef_active[i*DATA_WIDTH +: DATA_WIDTH] <= shadow[i];
      end
    end
  end

  // A completion on the same edge as a W1C keeps the flag set.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (core_done) result_q <= core_result;
      done_q <= core_done || (done_q && !done_clr);
    end
  end

`ifdef CELL_REGFILE_CYCLE_CNT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cycles_q <= '0;
    end else if (core_start) begin
      cycles_q <= '0;
    end else if (core_busy && cycles_q != '1) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_regfile.sv
// Directed bench for cell_regfile: register map, strobes, commit/start
// sequencing, done/result capture, error responses, back-pressure, reset.
module tb_cell_regfile;
  import cell_pkg::*;

  localparam int DW = 32;
  localparam int NC = 8;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NC*DW-1:0] coef_active;
  logic             core_start;
  logic             core_busy;
  logic             core_done;
  logic [DW-1:0]    core_result;

  int total = 0;
  int bad   = 0;
  int npulse = 0;

  cell_regfile_if #(.DATA_WIDTH(DW)) bus ();

  cell_regfile #(.DATA_WIDTH(DW), .NUM_COEF(NC)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .coef_active (coef_active),
    .core_start  (core_start),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (core_start) npulse++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic [1:0] rc);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick(1);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    tick(1);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    chk({tag, "_rvalid"}, 256'(bus.resp_valid), 256'(1));
    rd = bus.resp_rdata;
    rc = bus.resp_code;
    tick(1);
  endtask

  logic [31:0]      rd;
  logic [1:0]       rc;
  logic [NC*DW-1:0] exp_coef;
  int               p0;

  initial begin
    aresetn         = 1'b0;
    core_busy       = 1'b0;
    core_done       = 1'b0;
    core_result     = '0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.resp_ready  = 1'b1;
    tick(2);

    chk("rst_req_ready",  256'(bus.req_ready),  256'(1));
    chk("rst_resp_valid", 256'(bus.resp_valid), 256'(0));
    chk("rst_rdata",      256'(bus.resp_rdata), 256'(0));
    chk("rst_code",       256'(bus.resp_code),  256'(0));
    chk("rst_coef",       256'(coef_active),    256'(0));
    chk("rst_start",      256'(core_start),     256'(0));
    aresetn = 1'b1;
    tick(1);

    // Full-word shadow write does not touch the active bank
    xfer("wr_coef2", 1'b1, 8'h18, 32'h1234_5678, 4'hF, rd, rc);
    chk("wr_coef2_code", 256'(rc), 256'(RESP_OKAY));
    chk("wr_coef2_rdata", 256'(rd), 256'(0));
    xfer("rd_coef2", 1'b0, 8'h18, 32'h0, 4'h0, rd, rc);
    chk("rd_coef2_code", 256'(rc), 256'(RESP_OKAY));
    chk("rd_coef2_data", 256'(rd), 256'(32'h1234_5678));
    chk("coef_still_0", 256'(coef_active), 256'(0));

    // Byte strobes
    xfer("wr_coef0", 1'b1, 8'h10, 32'hAABB_CCDD, 4'h3, rd, rc);
    xfer("rd_coef0", 1'b0, 8'h10, 32'h0, 4'h0, rd, rc);
    chk("rd_coef0_data", 256'(rd), 256'(32'h0000_CCDD));
    xfer("wr_coef0b", 1'b1, 8'h13, 32'h1100_0000, 4'h8, rd, rc);
    xfer("rd_coef0b", 1'b0, 8'h10, 32'h0, 4'h0, rd, rc);
    chk("rd_coef0b_data", 256'(rd), 256'(32'h1100_CCDD));
    xfer("wr_coef0c", 1'b1, 8'h10, 32'h0000_CCDD, 4'hF, rd, rc);

    // Commit + start while busy, then release busy
    core_busy = 1'b1;
    p0 = npulse;
    xfer("wr_ctrl3", 1'b1, 8'h00, 32'h3, 4'h1, rd, rc);
    chk("wr_ctrl3_code", 256'(rc), 256'(RESP_OKAY));
    xfer("rd_status7", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("status_7", 256'(rd), 256'(32'h7));
    xfer("rd_ctrl", 1'b0, 8'h00, 32'h0, 4'h0, rd, rc);
    chk("ctrl_reads_0", 256'(rd), 256'(0));
    chk("busy_no_commit", 256'(coef_active), 256'(0));
    chk("busy_no_start", 256'(npulse - p0), 256'(0));
    exp_coef = '0;
    exp_coef[31:0]  = 32'h0000_CCDD;
    exp_coef[95:64] = 32'h1234_5678;
    core_busy = 1'b0;
    tick(1);
    chk("commit_applied", 256'(coef_active), 256'(exp_coef));
    chk("start_after_commit_0", 256'(core_start), 256'(0));
    tick(1);
    chk("start_pulse_1", 256'(core_start), 256'(1));
    tick(1);
    chk("start_pulse_end", 256'(core_start), 256'(0));
    tick(3);
    chk("start_once", 256'(npulse - p0), 256'(1));
    xfer("rd_status0", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("status_0_after", 256'(rd), 256'(0));

    // Repeated START while pending yields one pulse
    core_busy = 1'b1;
    p0 = npulse;
    xfer("wr_start_a", 1'b1, 8'h00, 32'h1, 4'h1, rd, rc);
    xfer("wr_start_b", 1'b1, 8'h00, 32'h1, 4'h1, rd, rc);
    xfer("rd_status5", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("status_5", 256'(rd), 256'(32'h5));
    core_busy = 1'b0;
    tick(5);
    chk("repeat_start_once", 256'(npulse - p0), 256'(1));
    chk("coef_unchanged", 256'(coef_active), 256'(exp_coef));

    // Completion capture and W1C
    core_done   = 1'b1;
    core_result = 32'hDEAD_BEEF;
    tick(1);
    core_done   = 1'b0;
    core_result = 32'h0;
    xfer("rd_result", 1'b0, 8'h08, 32'h0, 4'h0, rd, rc);
    chk("result_data", 256'(rd), 256'(32'hDEAD_BEEF));
    xfer("rd_status8", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("status_done", 256'(rd), 256'(32'h8));
    xfer("w1c_nostrb", 1'b1, 8'h04, 32'h8, 4'h0, rd, rc);
    xfer("rd_status8b", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("w1c_needs_strb", 256'(rd), 256'(32'h8));
    xfer("w1c", 1'b1, 8'h04, 32'h8, 4'h1, rd, rc);
    chk("w1c_code", 256'(rc), 256'(RESP_OKAY));
    xfer("rd_status0b", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("status_cleared", 256'(rd), 256'(0));

    // Error responses
    xfer("rd_unmapped", 1'b0, 8'h40, 32'h0, 4'h0, rd, rc);
    chk("unmapped_code", 256'(rc), 256'(RESP_DECERR));
    chk("unmapped_rdata", 256'(rd), 256'(0));
    xfer("wr_unmapped", 1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF, rd, rc);
    chk("wr_unmapped_code", 256'(rc), 256'(RESP_DECERR));
    xfer("wr_result", 1'b1, 8'h08, 32'h1111_2222, 4'hF, rd, rc);
    chk("wr_result_code", 256'(rc), 256'(RESP_SLVERR));
    xfer("rd_result2", 1'b0, 8'h08, 32'h0, 4'h0, rd, rc);
    chk("result_unchanged", 256'(rd), 256'(32'hDEAD_BEEF));
    xfer("rd_cycles", 1'b0, 8'h0C, 32'h0, 4'h0, rd, rc);
`ifdef CELL_REGFILE_CYCLE_CNT_EN
    chk("cycles_code", 256'(rc), 256'(RESP_OKAY));
`else
    chk("cycles_code", 256'(rc), 256'(RESP_DECERR));
`endif
    xfer("rd_coef7", 1'b0, 8'h2C, 32'h0, 4'h0, rd, rc);
    chk("coef7_code", 256'(rc), 256'(RESP_OKAY));

    // Back-pressure on the response
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 8'h18;
    tick(1);
    bus.req_valid  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", 256'(bus.resp_valid), 256'(1));
      chk("bp_rdata", 256'(bus.resp_rdata), 256'(32'h1234_5678));
      chk("bp_req_ready", 256'(bus.req_ready), 256'(0));
      tick(1);
    end
    bus.resp_ready = 1'b1;
    tick(1);
    chk("bp_released", 256'(bus.resp_valid), 256'(0));
    chk("bp_req_ready_back", 256'(bus.req_ready), 256'(1));

    // Reset while commit/start pending and a response outstanding
    xfer("wr_coef1", 1'b1, 8'h14, 32'h0000_0055, 4'hF, rd, rc);
    core_busy = 1'b1;
    xfer("wr_ctrl3b", 1'b1, 8'h00, 32'h3, 4'h1, rd, rc);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 8'h04;
    tick(1);
    bus.req_valid  = 1'b0;
    chk("pre_rst_resp", 256'(bus.resp_valid), 256'(1));
    aresetn = 1'b0;
    tick(1);
    chk("mid_rst_resp_valid", 256'(bus.resp_valid), 256'(0));
    chk("mid_rst_req_ready",  256'(bus.req_ready),  256'(1));
    chk("mid_rst_rdata",      256'(bus.resp_rdata), 256'(0));
    chk("mid_rst_coef",       256'(coef_active),    256'(0));
    chk("mid_rst_start",      256'(core_start),     256'(0));
    aresetn        = 1'b1;
    bus.resp_ready = 1'b1;
    core_busy      = 1'b0;
    p0 = npulse;
    tick(5);
    chk("post_rst_no_start", 256'(npulse - p0), 256'(0));
    chk("post_rst_coef", 256'(coef_active), 256'(0));
    xfer("rd_status_rst", 1'b0, 8'h04, 32'h0, 4'h0, rd, rc);
    chk("post_rst_status", 256'(rd), 256'(0));
    xfer("rd_coef1_rst", 1'b0, 8'h14, 32'h0, 4'h0, rd, rc);
    chk("post_rst_shadow", 256'(rd), 256'(0));
    xfer("rd_result_rst", 1'b0, 8'h08, 32'h0, 4'h0, rd, rc);
    chk("post_rst_result", 256'(rd), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
